// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
// DMType values mirror the processor-wide dm_* access-type defines.
package mem_access_unit_pkg;

    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } mau_state_e;

    // Replace one byte or halfword lane of old_w with the low bits of wd.
    function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                               input logic [31:0] wd,
                                               input logic [1:0]  lane,
                                               input logic        half);
        logic [31:0] field;
        logic [31:0] mask;
        logic [31:0] ins;
        field = half ? 32'h0000_FFFF : 32'h0000_00FF;
        mask  = field << {lane, 3'b000};
        ins   = (wd & field) << {lane, 3'b000};
        return (old_w & ~mask) | ins;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Lane select plus sign/zero extension of a memory word for loads.
module load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  dm_type,
    output logic [31:0] ext
);

    logic [31:0] shifted;

    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        case (dm_type)
            DM_HALFWORD:          ext = {{16{shifted[15]}}, shifted[15:0]};
            DM_HALFWORD_UNSIGNED: ext = {16'h0000, shifted[15:0]};
            DM_BYTE:              ext = {{24{shifted[7]}}, shifted[7:0]};
            DM_BYTE_UNSIGNED:     ext = {24'h00_0000, shifted[7:0]};
            default:              ext = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: sub-word stores become a stalled read-modify-write,
// and a one-entry pending register forwards dm's late-committing write to reads.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_en,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  DMType,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        DMWr,
    output logic        DMRe,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    mau_state_e     state, state_nxt;
    logic           pend_v;
    logic [AW-1:0]  pend_wa;
    logic [31:0]    pend_data;
    logic [31:0]    merged, merged_nxt;
    logic [29:0]    wr_addr;
    logic           capture;

    logic           is_half, is_byte, is_word, mis;
    logic           req_wr, req_rd;
    logic [31:0]    word_addr, fwd_word, ld_ext;

    assign is_half   = (DMType == DM_HALFWORD) || (DMType == DM_HALFWORD_UNSIGNED);
    assign is_byte   = (DMType == DM_BYTE) || (DMType == DM_BYTE_UNSIGNED);
    assign is_word   = !is_half && !is_byte;
    assign mis       = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign req_wr    = mem_en && MemWrite;
    assign req_rd    = mem_en && MemRead && !MemWrite;
    assign word_addr = {addr[31:2], 2'b00};

    // dm still shows the old word for one cycle after DMWr; the pending entry covers that gap.
    assign fwd_word = (pend_v && (pend_wa == addr[AW+1:2])) ? pend_data : dm_dout;

    load_ext u_load_ext (
        .word    (fwd_word),
        .lane    (addr[1:0]),
        .dm_type (DMType),
        .ext     (ld_ext)
    );

    always_comb begin
        state_nxt  = state;
        merged_nxt = merged;
        capture    = 1'b0;
        stall      = 1'b0;
        misalign   = 1'b0;
        DMWr       = 1'b0;
        DMRe       = 1'b0;
        rdata      = '0;
        dm_addr    = '0;
        dm_din     = '0;
        if (rstn) begin
            case (state)
                ST_IDLE: begin
                    if (req_wr || req_rd) begin
                        if (mis) begin
                            misalign = 1'b1;
                        end else if (req_wr && is_word) begin
                            DMWr    = 1'b1;
                            dm_addr = word_addr;
                            dm_din  = wdata;
                        end else if (req_wr) begin
                            DMRe       = 1'b1;
                            stall      = 1'b1;
                            dm_addr    = word_addr;
                            capture    = 1'b1;
                            merged_nxt = merge_lane(fwd_word, wdata, addr[1:0], is_half);
                            state_nxt  = ST_WRITE;
                        end else begin
                            DMRe    = 1'b1;
                            dm_addr = word_addr;
                            rdata   = ld_ext;
                        end
                    end
                end
                ST_WRITE: begin
                    DMWr      = 1'b1;
                    dm_addr   = {wr_addr, 2'b00};
                    dm_din    = merged;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Control state: FSM, pending-valid and merge register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            pend_v <= 1'b0;
            merged <= '0;
        end else begin
            state  <= state_nxt;
            pend_v <= DMWr;
            merged <= merged_nxt;
        end
    end

    // Data captured alongside the control state, qualified by pend_v / state
    always_ff @(posedge clk) begin
        if (DMWr) begin
            pend_wa   <= dm_addr[AW+1:2];
            pend_data <= dm_din;
        end
        if (capture) begin
            wr_addr <= addr[31:2];
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: spec vector table, reset-during-RMW sequence and
// random traffic checked against a byte-array program-order memory model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_en, MemRead, MemWrite;
    logic [2:0]  DMType;
    logic [31:0] addr, wdata, rdata, dm_addr, dm_din, dm_dout;
    logic        stall, misalign, DMWr, DMRe;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.AW(7)) dut (
        .clk(clk), .rstn(rstn), .mem_en(mem_en), .MemRead(MemRead), .MemWrite(MemWrite),
        .DMType(DMType), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .misalign(misalign), .DMWr(DMWr), .DMRe(DMRe), .dm_addr(dm_addr),
        .dm_din(dm_din), .dm_dout(dm_dout)
    );

    // Data memory with one-cycle-late write commit and asynchronous read
    logic [31:0] dmem [0:127];
    logic        clr, wr_q;
    logic [6:0]  wa_q;
    logic [31:0] wd_q;

    assign dm_dout = dmem[dm_addr[8:2]];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 128; i++) dmem[i] <= '0;
            wr_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
        end else begin
            if (wr_q) dmem[wa_q] <= wd_q;
            wr_q <= DMWr;
            wa_q <= dm_addr[8:2];
            wd_q <= dm_din;
        end
    end

    // Reference: byte memory updated in program order the moment a store is accepted
    logic [7:0] rmem [0:511];

    function automatic int acc_size(input logic [2:0] t);
        case (t)
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: return 2;
            DM_BYTE, DM_BYTE_UNSIGNED:         return 1;
            default:                           return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < acc_size(t); i++) v[8*i +: 8] = rmem[int'((a + i) & 32'h1FF)];
        if (t == DM_HALFWORD) v = {{16{v[15]}}, v[15:0]};
        if (t == DM_BYTE)     v = {{24{v[7]}}, v[7:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] t, input logic [31:0] wd);
        for (int i = 0; i < acc_size(t); i++) rmem[int'((a + i) & 32'h1FF)] = wd[8*i +: 8];
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one MEM-stage instruction; entered and left #1 after a rising edge.
    task automatic op(input logic en, input logic w, input logic r, input logic [2:0] t,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd_o, output logic mis_o, output logic stall_o);
        logic is_st, is_ld, mis, sub;
        int   sz;
        sz    = acc_size(t);
        is_st = en && w;
        is_ld = en && r && !w;
        mis   = (is_st || is_ld) && ((a & (sz - 1)) != 0);
        sub   = is_st && !mis && (sz < 4);
        mem_en = en; MemWrite = w; MemRead = r; DMType = t; addr = a; wdata = wd;
        @(negedge clk);
        rd_o = rdata; mis_o = misalign; stall_o = stall;
        check("misalign", {31'd0, misalign}, {31'd0, mis});
        check("DMWr", {31'd0, DMWr}, {31'd0, is_st && !mis && !sub});
        check("DMRe", {31'd0, DMRe}, {31'd0, (is_ld || sub) && !mis});
        check("stall", {31'd0, stall}, {31'd0, sub});
        if (is_ld && !mis)     check("rdata", rdata, ref_load(a, t));
        else if (!is_st)       check("rdata_zero", rdata, 32'h0);
        if ((is_st || is_ld) && !mis) check("dm_addr", dm_addr, {a[31:2], 2'b00});
        if (is_st && !mis && !sub)    check("dm_din", dm_din, wd);
        @(posedge clk); #1;
        if (is_st && !mis) ref_store(a, t, wd);
        if (sub) begin
            @(negedge clk);
            check("rmw_stall", {31'd0, stall}, 32'h0);
            check("rmw_DMWr", {31'd0, DMWr}, 32'h1);
            check("rmw_addr", dm_addr, {a[31:2], 2'b00});
            check("rmw_din", dm_din, ref_load({a[31:2], 2'b00}, DM_WORD));
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        mem_en = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        exp_stall;
    } vec_t;

    vec_t vt [17];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        mis, stl;

        vt[0]  = '{1'b1, 1'b0, DM_WORD,          32'h30, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, DM_WORD,          32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, DM_WORD,          32'h10, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, DM_WORD,          32'h20, 32'h1122_3344, 1'b0, 32'h0,         1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, DM_BYTE,          32'h21, 32'h0000_0080, 1'b0, 32'h0,         1'b0, 1'b1};
        vt[5]  = '{1'b0, 1'b1, DM_WORD,          32'h20, 32'h0,         1'b1, 32'h1122_8044, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, DM_BYTE,          32'h21, 32'h0,         1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, DM_BYTE_UNSIGNED, 32'h21, 32'h0,         1'b1, 32'h0000_0080, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, DM_WORD,          32'h30, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, DM_HALFWORD,      32'h32, 32'h0000_ABCD, 1'b0, 32'h0,         1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b1, DM_WORD,          32'h30, 32'h0,         1'b1, 32'hABCD_0000, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, DM_HALFWORD,      32'h32, 32'h0,         1'b1, 32'hFFFF_ABCD, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, DM_WORD,          32'h13, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0};
        vt[13] = '{1'b1, 1'b0, DM_HALFWORD,      32'h15, 32'h0000_1234, 1'b0, 32'h0,         1'b1, 1'b0};
        vt[14] = '{1'b0, 1'b1, DM_WORD,          32'h14, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0};
        vt[15] = '{1'b1, 1'b1, DM_WORD,          32'h50, 32'h5A5A_5A5A, 1'b0, 32'h0,         1'b0, 1'b0};
        vt[16] = '{1'b0, 1'b1, DM_WORD,          32'h50, 32'h0,         1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0};

        for (int i = 0; i < 512; i++) rmem[i] = 8'h00;

        // Reset with a live load request on the inputs: every output must be 0
        clr = 1'b1; rstn = 1'b0;
        mem_en = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; DMType = DM_WORD;
        addr = 32'h10; wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {28'd0, stall, misalign, DMWr, DMRe}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_dm_addr", dm_addr, 32'h0);
        check("reset_dm_din", dm_din, 32'h0);
        mem_en = 1'b0; MemRead = 1'b0; clr = 1'b0;
        @(posedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            op(1'b1, vt[i].w, vt[i].r, vt[i].t, vt[i].a, vt[i].wd, rd, mis, stl);
            if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            check($sformatf("vec%0d_misalign", i), {31'd0, mis}, {31'd0, vt[i].exp_mis});
            check($sformatf("vec%0d_stall", i), {31'd0, stl}, {31'd0, vt[i].exp_stall});
        end

        // Reset pulled during the WRITE cycle of a byte store to 0x40
        op(1'b1, 1'b1, 1'b0, DM_WORD, 32'h40, 32'h1234_5678, rd, mis, stl);
        idle(); idle();
        mem_en = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; DMType = DM_BYTE;
        addr = 32'h40; wdata = 32'h0000_00EE;
        @(negedge clk);
        check("rst_rmw_stall", {31'd0, stall}, 32'h1);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("rst_rmw_DMWr", {31'd0, DMWr}, 32'h0);
        check("rst_rmw_stall_low", {31'd0, stall}, 32'h0);
        mem_en = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1;
        idle();
        op(1'b1, 1'b0, 1'b1, DM_WORD, 32'h40, 32'h0, rd, mis, stl);
        check("rst_rmw_old_value", rd, 32'h1234_5678);
        op(1'b1, 1'b0, 1'b1, DM_BYTE_UNSIGNED, 32'h40, 32'h0, rd, mis, stl);
        check("rst_rmw_old_byte", rd, 32'h0000_0078);

        // Random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            logic        en, w, r;
            logic [2:0]  t;
            logic [31:0] a, wd;
            en = ($urandom_range(0, 9) != 0);
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            t  = 3'($urandom_range(0, 4));
            a  = 32'($urandom_range(0, 127));
            wd = $urandom;
            op(en, w, r, t, a, wd, rd, mis, stl);
        end

        // Final sweep: every word must read back its program-order value
        for (int i = 0; i < 32; i++) begin
            op(1'b1, 1'b0, 1'b1, DM_WORD, 32'(i * 4), 32'h0, rd, mis, stl);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
